// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer of the small async FIFO.
// Turns the FIFO's show-ahead read port into a registered valid/ready stream
// through a 2-entry output buffer. Includes a flush state machine that drops
// buffered words and drains the FIFO.
//
// Optional feature macro: FIFO_RD_STREAM_STATS_EN
//   When defined, adds saturating stat_words / stat_starve counters (CNT_W bits).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal streaming; pop while buffer has room
// ST_FLUSH | buffer cleared, out_valid low, pop and discard until rempty
module fifo_rd_stream #(
   parameter int DSIZE = 8,
   parameter int CNT_W = 32
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   input  logic             r_almost_empty,
   output logic             rinc,
   output logic [DSIZE-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_low,
   input  logic             flush,
   output logic             flush_done
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_words,
   output logic [CNT_W-1:0] stat_starve
`endif
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [DSIZE-1:0] head_q, head_d;
   logic [DSIZE-1:0] tail_q, tail_d;
   logic             low_q;
   logic             xfer;

   assign out_data = head_q;
   assign out_low  = low_q;

   // Next-state, pop strobe and buffer steering; rinc depends only on
   // registered state and rempty so out_ready never reaches the FIFO.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      head_d     = head_q;
      tail_d     = tail_q;
      rinc       = 1'b0;
      flush_done = 1'b0;
      out_valid  = (cnt_q != 2'd0) && (state_q == ST_RUN);
      xfer       = out_valid && out_ready;

      case (state_q)
         ST_RUN: begin
            rinc = !rempty && (cnt_q != 2'd2) && !rrst;
            if (flush) begin
               // Flush wins over any same-cycle transfer or push.
               state_d = ST_FLUSH;
               cnt_d   = 2'd0;
            end else begin
               case ({rinc, xfer})
                  2'b10: begin
                     if (cnt_q == 2'd0) begin
                        head_d = rdata;
                     end else begin
                        tail_d = rdata;
                     end
                     cnt_d = cnt_q + 2'd1;
                  end
                  2'b01: begin
                     head_d = tail_q;
                     cnt_d  = cnt_q - 2'd1;
                  end
                  2'b11: begin
                     // Head leaves; new word lands behind whatever remains.
                     if (cnt_q == 2'd1) begin
                        head_d = rdata;
                     end else begin
                        head_d = tail_q;
                        tail_d = rdata;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
         ST_FLUSH: begin
            rinc  = !rempty && !rrst;
            cnt_d = 2'd0;
            if (rempty) begin
               state_d    = ST_RUN;
               flush_done = !rrst;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
         end
      endcase
   end

   // State, buffer and almost-empty registers with synchronous reset.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_q <= ST_RUN;
         cnt_q   <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
         low_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         low_q   <= r_almost_empty;
      end
   end

`ifdef FIFO_RD_STREAM_STATS_EN
   logic [CNT_W-1:0] words_q;
   logic [CNT_W-1:0] starve_q;

   assign stat_words  = words_q;
   assign stat_starve = starve_q;

   // Saturating transfer and starvation counters, frozen outside normal RUN.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         words_q  <= '0;
         starve_q <= '0;
      end else if ((state_q == ST_RUN) && !flush) begin
         if (xfer && (words_q != {CNT_W{1'b1}})) begin
            words_q <= words_q + 1'b1;
         end
         if (out_ready && !out_valid && (starve_q != {CNT_W{1'b1}})) begin
            starve_q <= starve_q + 1'b1;
         end
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: queue-based FIFO environment and
// queue-based reference model of the output buffer.
module tb_fifo_rd_stream;

   localparam int DSIZE = 8;
`ifdef FIFO_RD_STREAM_STATS_EN
   localparam int CW = 4;
`else
   localparam int CW = 32;
`endif
   localparam longint SAT = (64'd1 << CW) - 1;

   logic             rclk;
   logic             rrst;
   logic [DSIZE-1:0] rdata;
   logic             rempty;
   logic             r_almost_empty;
   logic             rinc;
   logic [DSIZE-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_low;
   logic             flush;
   logic             flush_done;
`ifdef FIFO_RD_STREAM_STATS_EN
   logic [CW-1:0]    stat_words;
   logic [CW-1:0]    stat_starve;
`endif

   fifo_rd_stream #(.DSIZE(DSIZE), .CNT_W(CW)) dut (
      .rclk           (rclk),
      .rrst           (rrst),
      .rdata          (rdata),
      .rempty         (rempty),
      .r_almost_empty (r_almost_empty),
      .rinc           (rinc),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_low        (out_low),
      .flush          (flush),
      .flush_done     (flush_done)
`ifdef FIFO_RD_STREAM_STATS_EN
      ,
      .stat_words     (stat_words),
      .stat_starve    (stat_starve)
`endif
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   int checks = 0;
   int errors = 0;

   // environment FIFO and reference model
   logic [DSIZE-1:0] fifo_q[$];
   logic [DSIZE-1:0] mbuf[$];
   bit               mflush;
   bit               mlow;
   longint           mwords, mstarve;

   bit               e_rinc, e_valid, e_fdone, d_rinc;
   logic [DSIZE-1:0] e_data;
   logic [11:0]      obs, expv;

   task automatic prep();
      rempty = (fifo_q.size() == 0);
      rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
      #1;
      e_rinc  = !rrst && !rempty && (mflush || mbuf.size() < 2);
      e_valid = !mflush && (mbuf.size() != 0);
      e_data  = e_valid ? mbuf[0] : '0;
      e_fdone = !rrst && mflush && rempty;
      d_rinc  = rinc;
      obs  = {rinc, out_valid, (out_valid ? out_data : 8'h00), flush_done, out_low};
      expv = {e_rinc, e_valid, e_data, e_fdone, mlow};
   endtask

   task automatic clk_edge();
      bit               xf, p_rrst, p_flush, p_ready, p_ae, p_empty;
      logic [DSIZE-1:0] p_data;
      xf = e_valid && out_ready;
      p_rrst = rrst; p_flush = flush; p_ready = out_ready;
      p_ae = r_almost_empty; p_empty = rempty; p_data = rdata;
      @(posedge rclk);
      if (p_rrst) begin
         mbuf.delete(); mflush = 0; mlow = 1; mwords = 0; mstarve = 0;
      end else begin
         mlow = p_ae;
         if (!mflush) begin
            if (p_flush) begin
               mbuf.delete(); mflush = 1;
            end else begin
               if (xf) begin
                  void'(mbuf.pop_front());
                  if (mwords < SAT) mwords++;
               end
               if (p_ready && !e_valid && mstarve < SAT) mstarve++;
               if (e_rinc) mbuf.push_back(p_data);
            end
         end else if (p_empty) begin
            mflush = 0;
         end
      end
      if (d_rinc && fifo_q.size() != 0) void'(fifo_q.pop_front());
      #2;
   endtask

   task automatic do_reset();
      fifo_q.delete();
      rrst = 1; out_ready = 0; flush = 0;
      prep(); clk_edge();
      rrst = 0;
   endtask

   task automatic test_reset();
      int pops = 0;
      fifo_q.delete();
      fifo_q.push_back(8'hA1); fifo_q.push_back(8'hB2); fifo_q.push_back(8'hC3);
      rrst = 1; out_ready = 0; flush = 0; r_almost_empty = 0;
      prep(); clk_edge();
      prep();
      checks++;
      if ({rinc, out_valid, out_data, flush_done, out_low} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state got=%h want=%h", {rinc, out_valid, out_data, flush_done, out_low}, 12'h001);
      end
      clk_edge();
      rrst = 0;
      for (int i = 0; i < 6; i++) begin
         prep();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL reset_release cyc=%0d got=%h want=%h", i, obs, expv); end
         if (rinc) pops++;
         clk_edge();
      end
      prep();
      checks++;
      if (pops != 2) begin errors++; $display("FAIL reset_pops got=%0d want=2", pops); end
      checks++;
      if (!(out_valid === 1'b1 && out_data === 8'hA1)) begin
         errors++; $display("FAIL reset_head got=%b/%h want=1/a1", out_valid, out_data);
      end
   endtask

   task automatic test_stream();
      int nx = 0, nr = 0, first = -1, last = -1, firstr = -1, lastr = -1;
      do_reset();
      for (int i = 0; i < 16; i++) fifo_q.push_back(8'($urandom));
      out_ready = 1;
      for (int i = 0; i < 22; i++) begin
         prep();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL stream cyc=%0d got=%h want=%h", i, obs, expv); end
         if (out_valid) begin nx++; if (first < 0) first = i; last = i; end
         if (rinc) begin nr++; if (firstr < 0) firstr = i; lastr = i; end
         clk_edge();
      end
      checks++;
      if (nx != 16 || last - first + 1 != 16) begin
         errors++; $display("FAIL stream_valid_run got=%0d/%0d want=16", nx, last - first + 1);
      end
      checks++;
      if (nr != 16 || lastr - firstr + 1 != 16 || firstr != 0) begin
         errors++; $display("FAIL stream_rinc_run got=%0d/%0d want=16", nr, lastr - firstr + 1);
      end
   endtask

   task automatic test_backpressure();
      int nx = 0, popped = 0, maxfl = 0;
      bit               pv = 0, pr = 0;
      logic [DSIZE-1:0] pd = '0;
      do_reset();
      for (int i = 0; i < 8; i++) fifo_q.push_back(8'($urandom));
      for (int i = 0; i < 40 && nx < 8; i++) begin
         out_ready = (i % 2 == 0);
         prep();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL backpressure cyc=%0d got=%h want=%h", i, obs, expv); end
         if (pv && !pr) begin
            checks++;
            if (!(out_valid === 1'b1 && out_data === pd)) begin
               errors++; $display("FAIL stall_stable got=%b/%h want=1/%h", out_valid, out_data, pd);
            end
         end
         pv = out_valid; pr = out_ready; pd = out_data;
         if (out_valid && out_ready) nx++;
         if (rinc) popped++;
         if (popped - nx > maxfl) maxfl = popped - nx;
         clk_edge();
      end
      checks++;
      if (nx != 8 || maxfl > 2) begin
         errors++; $display("FAIL backpressure_count got=%0d/%0d want=8/<=2", nx, maxfl);
      end
   endtask

   task automatic test_flush();
      int pops = 0, fd = 0, nx = 0;
      logic [DSIZE-1:0] got = '0;
      do_reset();
      for (int i = 0; i < 7; i++) fifo_q.push_back(8'(i + 8'h10));
      for (int i = 0; i < 3; i++) begin prep(); clk_edge(); end
      flush = 1;
      prep();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL flush_req got=%h want=%h", obs, expv); end
      clk_edge();
      flush = 0;
      for (int i = 0; i < 12 && fd == 0; i++) begin
         prep();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL flush_drain cyc=%0d got=%h want=%h", i, obs, expv); end
         if (rinc) pops++;
         if (flush_done) fd++;
         clk_edge();
      end
      prep();
      checks++;
      if (pops != 5 || fd != 1 || flush_done !== 1'b0) begin
         errors++; $display("FAIL flush_drain_count got=%0d/%0d want=5/1", pops, fd);
      end
      fifo_q.push_back(8'h5A);
      out_ready = 1;
      for (int i = 0; i < 6 && nx == 0; i++) begin
         prep();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL flush_after cyc=%0d got=%h want=%h", i, obs, expv); end
         if (out_valid) begin nx++; got = out_data; end
         clk_edge();
      end
      checks++;
      if (nx != 1 || got !== 8'h5A) begin errors++; $display("FAIL flush_next_word got=%h want=5a", got); end
   endtask

   task automatic test_flush_xfer();
      longint w0;
      do_reset();
      fifo_q.push_back(8'h77);
      for (int i = 0; i < 3; i++) begin prep(); clk_edge(); end
      w0 = mwords;
      out_ready = 1; flush = 1;
      prep();
      checks++;
      if (obs !== expv || out_valid !== 1'b1) begin errors++; $display("FAIL flush_xfer_req got=%h want=%h", obs, expv); end
      clk_edge();
      flush = 0;
      prep();
      checks++;
      if (out_valid !== 1'b0 || flush_done !== 1'b1) begin
         errors++; $display("FAIL flush_xfer_drop got=%b/%b want=0/1", out_valid, flush_done);
      end
`ifdef FIFO_RD_STREAM_STATS_EN
      checks++;
      if (longint'(stat_words) != w0 || w0 != 0) begin
         errors++; $display("FAIL flush_xfer_stat got=%0d want=0", stat_words);
      end
`endif
      clk_edge();
      prep();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL flush_xfer_after got=%h want=%h", obs, expv); end
      out_ready = 0;
      clk_edge();
   endtask

`ifdef FIFO_RD_STREAM_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int round = 0; round < 2; round++) begin
         out_ready = (round == 0);
         for (int i = 0; i < 4; i++) begin prep(); clk_edge(); end
         out_ready = 0;
         for (int i = 0; i < 10; i++) fifo_q.push_back(8'($urandom));
         for (int i = 0; i < 3; i++) begin prep(); clk_edge(); end
         out_ready = 1;
         for (int i = 0; i < 10; i++) begin
            prep();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL stats_stream cyc=%0d got=%h want=%h", i, obs, expv); end
            clk_edge();
         end
         out_ready = 0;
         prep();
         checks++;
         if (round == 0 && (stat_words !== 4'd10 || stat_starve !== 4'd4)) begin
            errors++; $display("FAIL stats_counts got=%0d/%0d want=10/4", stat_words, stat_starve);
         end
         checks++;
         if (round == 1 && (stat_words !== 4'd15 || stat_starve !== 4'd4)) begin
            errors++; $display("FAIL stats_saturate got=%0d/%0d want=15/4", stat_words, stat_starve);
         end
         clk_edge();
      end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(1, 0) == 1 && fifo_q.size() < 8) fifo_q.push_back(8'($urandom));
         out_ready      = ($urandom_range(3, 0) != 0);
         flush          = ($urandom_range(39, 0) == 0);
         rrst           = ($urandom_range(120, 0) == 0);
         r_almost_empty = (fifo_q.size() < 2) ^ ($urandom_range(7, 0) == 0);
         prep();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, expv); end
`ifdef FIFO_RD_STREAM_STATS_EN
         checks++;
         if (longint'(stat_words) != mwords || longint'(stat_starve) != mstarve) begin
            errors++; $display("FAIL random_stats cyc=%0d got=%0d/%0d want=%0d/%0d", i, stat_words, stat_starve, mwords, mstarve);
         end
`endif
         clk_edge();
      end
      rrst = 0; flush = 0;
   endtask

   initial begin
      rrst = 1; flush = 0; out_ready = 0; r_almost_empty = 0;
      rempty = 1; rdata = '0;
      mflush = 0; mlow = 1; mwords = 0; mstarve = 0;
      #2;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_flush_xfer();
`ifdef FIFO_RD_STREAM_STATS_EN
      test_stats();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
